// File: rtl/portal_arbiter.sv
// portal_arbiter: round-robin arbiter feeding a one-entry output buffer.
// Ports:
//   CLK, nRST                           clock, async active-low reset
//   req_enq__ENA/_v/__RDY               per-requester send handshake
//   pipe_enq__ENA/_v/__RDY              downstream pipe handshake
//   last_grant                          index of last accepted requester
//   msg_count                           messages delivered since reset
module portal_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 96
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic [NUM_REQ-1:0]            req_enq__ENA,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_enq_v,
  output logic [NUM_REQ-1:0]            req_enq__RDY,
  output logic                          pipe_enq__ENA,
  output logic [DATA_WIDTH-1:0]         pipe_enq_v,
  input  logic                          pipe_enq__RDY,
  output logic [2:0]                    last_grant,
  output logic [15:0]                   msg_count
);

  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [2:0]            ptr;
  logic                  can_accept;
  logic                  hit;
  logic                  accept;
  logic [2:0]            gidx;
  logic [2:0]            ptr_nxt;
  logic [DATA_WIDTH-1:0] sel_data;

  // Grants stay low while reset is held even if the buffer is empty.
  assign can_accept = nRST & (~buf_full | pipe_enq__RDY);

  // Rotating priority as two passes: first from ptr upward,
  // then wrap around from index 0.
  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && req_enq__ENA[i] && i >= int'(ptr)) begin
        hit  = 1'b1;
        gidx = 3'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && req_enq__ENA[i]) begin
        hit  = 1'b1;
        gidx = 3'(i);
      end
    end
  end

  assign accept = hit & can_accept;

  always_comb begin
    req_enq__RDY = '0;
    sel_data     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && gidx == 3'(i)) begin
        req_enq__RDY[i] = 1'b1;
        sel_data = req_enq_v[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign ptr_nxt = (gidx == 3'(NUM_REQ-1)) ? 3'd0
                                           : gidx + 3'd1;

  assign pipe_enq__ENA = buf_full & pipe_enq__RDY;
  assign pipe_enq_v    = buf_data;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      buf_full   <= 1'b0;
      buf_data   <= '0;
      ptr        <= '0;
      last_grant <= '0;
      msg_count  <= '0;
    end else begin
      // A fresh acceptance refills the slot being drained.
      if (accept) begin
        buf_full   <= 1'b1;
        buf_data   <= sel_data;
        last_grant <= gidx;
        ptr        <= ptr_nxt;
      end else if (pipe_enq__ENA) begin
        buf_full <= 1'b0;
      end
      if (pipe_enq__ENA) begin
        msg_count <= msg_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_portal_arbiter.sv
// tb_portal_arbiter: vector table, hand sequences and random
// stimulus against a queue-based reference model.
module tb_portal_arbiter;

  localparam int N  = 4;
  localparam int DW = 96;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    ena;
  logic [N*DW-1:0] vin;
  logic [N-1:0]    rdy;
  logic            pen;
  logic [DW-1:0]   pv;
  logic            prdy;
  logic [2:0]      last;
  logic [15:0]     cnt;

  int checks = 0;
  int errors = 0;

  portal_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .CLK           (clk),
    .nRST          (rst_n),
    .req_enq__ENA  (ena),
    .req_enq_v     (vin),
    .req_enq__RDY  (rdy),
    .pipe_enq__ENA (pen),
    .pipe_enq_v    (pv),
    .pipe_enq__RDY (prdy),
    .last_grant    (last),
    .msg_count     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dat(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'h0F0F_0F0F,
            32'h0000_1000 + 32'(i)};
  endfunction

  task automatic set_fixed_data();
    for (int i = 0; i < N; i++) vin[i*DW +: DW] = dat(i);
  endtask

  task automatic do_reset();
    ena   = '0;
    prdy  = 1'b0;
    #2;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] ena;
    logic         prdy;
    logic [N-1:0] rdy;
    logic         pen;
    int           src;
    logic [2:0]   last;
    logic [15:0]  cnt;
  } vec_t;

  vec_t tbl[20];

  // reference model state
  logic [DW-1:0] mq[$];
  int            mptr;
  int            mlast;
  logic [15:0]   mcnt;
  logic          pend[N];
  logic [DW-1:0] pdat[N];
  int            waits[N];

  initial begin
    rst_n = 1'b1;
    ena   = '0;
    vin   = '0;
    prdy  = 1'b0;

    tbl[0]  = '{4'b1111, 1, 4'b0001, 0, -1, 0, 0};
    tbl[1]  = '{4'b1111, 1, 4'b0010, 1,  0, 0, 0};
    tbl[2]  = '{4'b1111, 1, 4'b0100, 1,  1, 1, 1};
    tbl[3]  = '{4'b1111, 1, 4'b1000, 1,  2, 2, 2};
    tbl[4]  = '{4'b1111, 1, 4'b0001, 1,  3, 3, 3};
    tbl[5]  = '{4'b0000, 1, 4'b0000, 1,  0, 0, 4};
    tbl[6]  = '{4'b0000, 1, 4'b0000, 0, -1, 0, 5};
    tbl[7]  = '{4'b0100, 1, 4'b0100, 0, -1, 0, 5};
    tbl[8]  = '{4'b0101, 1, 4'b0001, 1,  2, 2, 5};
    tbl[9]  = '{4'b0101, 1, 4'b0100, 1,  0, 0, 6};
    tbl[10] = '{4'b0101, 1, 4'b0001, 1,  2, 2, 7};
    tbl[11] = '{4'b0000, 0, 4'b0000, 0,  0, 0, 8};
    tbl[12] = '{4'b0010, 0, 4'b0000, 0,  0, 0, 8};
    tbl[13] = '{4'b0010, 1, 4'b0010, 1,  0, 0, 8};
    tbl[14] = '{4'b0000, 1, 4'b0000, 1,  1, 1, 9};
    tbl[15] = '{4'b0000, 0, 4'b0000, 0, -1, 1, 10};
    tbl[16] = '{4'b1000, 0, 4'b1000, 0, -1, 1, 10};
    tbl[17] = '{4'b0001, 0, 4'b0000, 0,  3, 3, 10};
    tbl[18] = '{4'b0001, 1, 4'b0001, 1,  3, 3, 10};
    tbl[19] = '{4'b0000, 1, 4'b0000, 1,  0, 0, 11};

    // reset state, with requests pending during reset
    #2;
    rst_n = 1'b0;
    ena   = '1;
    prdy  = 1'b1;
    set_fixed_data();
    #3;
    chk("rst_rdy",  96'(rdy),  96'(0));
    chk("rst_pen",  96'(pen),  96'(0));
    chk("rst_cnt",  96'(cnt),  96'(0));
    chk("rst_last", 96'(last), 96'(0));
    tick();
    tick();
    rst_n = 1'b1;

    // vector table
    for (int k = 0; k < 20; k++) begin
      ena  = tbl[k].ena;
      prdy = tbl[k].prdy;
      #3;
      chk($sformatf("v%0d_rdy", k), 96'(rdy), 96'(tbl[k].rdy));
      chk($sformatf("v%0d_pen", k), 96'(pen), 96'(tbl[k].pen));
      chk($sformatf("v%0d_last", k), 96'(last), 96'(tbl[k].last));
      chk($sformatf("v%0d_cnt", k), 96'(cnt), 96'(tbl[k].cnt));
      if (tbl[k].src >= 0)
        chk($sformatf("v%0d_v", k), pv, dat(tbl[k].src));
      tick();
    end

    // reset mid-operation drops the buffered message
    do_reset();
    ena  = 4'b0010;
    prdy = 1'b0;
    #3;
    chk("ar_grant", 96'(rdy), 96'(4'b0010));
    tick();
    ena = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pen0", 96'(pen), 96'(0));
    prdy = 1'b1;
    ena  = '1;
    #1;
    chk("ar_pen1", 96'(pen), 96'(0));
    chk("ar_rdy",  96'(rdy), 96'(0));
    chk("ar_cnt",  96'(cnt), 96'(0));
    ena = '0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("ar_nodeliver", 96'(pen), 96'(0));
      tick();
    end
    chk("ar_cnt_after", 96'(cnt), 96'(0));

    // single requester, first grant from ptr 0
    vin[2*DW +: DW] = {80'h0, 16'hABCD};
    ena = 4'b0100;
    #3;
    chk("s_rdy", 96'(rdy), 96'(4'b0100));
    tick();
    ena = '0;
    #3;
    chk("s_pen",  96'(pen),  96'(1));
    chk("s_v",    pv,        {80'h0, 16'hABCD});
    chk("s_last", 96'(last), 96'(2));
    tick();
    #3;
    chk("s_cnt", 96'(cnt), 96'(1));
    chk("s_pen_off", 96'(pen), 96'(0));

    // msg_count wrap
    do_reset();
    set_fixed_data();
    ena  = 4'b0001;
    prdy = 1'b1;
    for (int k = 0; k < 65536; k++) tick();
    #3;
    chk("wrap_ffff", 96'(cnt), 96'(16'hFFFF));
    chk("wrap_pen",  96'(pen), 96'(1));
    tick();
    #3;
    chk("wrap_0000", 96'(cnt), 96'(0));

    // random stimulus vs reference model
    do_reset();
    mq.delete();
    mptr  = 0;
    mlast = 0;
    mcnt  = '0;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      pdat[i]  = '0;
      waits[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      int g;
      logic can;
      logic epen;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          pdat[i]  = {$urandom, $urandom, $urandom};
          waits[i] = 0;
        end
        ena[i] = pend[i];
        vin[i*DW +: DW] = pdat[i];
      end
      prdy = ($urandom_range(0, 3) != 0);
      #3;
      can  = (mq.size() == 0) || prdy;
      epen = (mq.size() > 0) && prdy;
      g = -1;
      if (can) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (mptr + k) % N;
          if (g < 0 && pend[j]) g = j;
        end
      end
      chk("r_rdy", 96'(rdy),
          96'((g >= 0) ? (1 << g) : 0));
      chk("r_pen",  96'(pen),  96'(epen));
      chk("r_last", 96'(last), 96'(mlast));
      chk("r_cnt",  96'(cnt),  96'(mcnt));
      if (mq.size() > 0) chk("r_v", pv, mq[0]);
      if (epen) begin
        void'(mq.pop_front());
        mcnt = mcnt + 16'd1;
      end
      if (g >= 0) begin
        chk("r_starve", 96'(waits[g] <= N - 1), 96'(1));
        for (int i = 0; i < N; i++)
          if (pend[i] && i != g) waits[i]++;
        mq.push_back(pdat[g]);
        mlast   = g;
        mptr    = (g + 1) % N;
        pend[g] = 1'b0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/portal_arbiter.md
PORTAL_ARBITER -- requirements
Module: portal_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing the output pipe (2..8).
REQ-002 Parameter DATA_WIDTH, 96, width of one pipe message word.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 req$enq__ENA  input  NUM_REQ  per-requester send request; bit i high means requester i presents a message.
REQ-006 req$enq_v  input  NUM_REQ*DATA_WIDTH  per-requester message; slice i is bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 req$enq__RDY  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 pipe$enq__ENA  output  1  message valid toward downstream pipe.
REQ-009 pipe$enq_v  output  DATA_WIDTH  message toward downstream pipe.
REQ-010 pipe$enq__RDY  input  1  downstream can take a message this cycle.
REQ-011 last_grant  output  3  index of the most recently accepted requester.
REQ-012 msg_count  output  16  number of messages delivered downstream since reset.

Function
REQ-013 A message from requester i is accepted in a cycle iff req$enq__ENA[i] and req$enq__RDY[i] are both high.
REQ-014 req$enq__RDY SHALL depend only on req$enq__ENA, internal state and pipe$enq__RDY; requesters hold ENA and data stable until accepted.
REQ-015 State: one-entry output buffer (buf_full, buf_data), round-robin pointer ptr (0..NUM_REQ-1), last_grant, msg_count.
REQ-016 can_accept = !buf_full | pipe$enq__RDY (drain and fill in the same cycle is allowed).
REQ-017 Grant: when can_accept, req$enq__RDY[g]=1 for the first requester g with ENA high, searching ptr, ptr+1, ... modulo NUM_REQ; all other bits 0; all bits 0 when !can_accept or no ENA.
REQ-018 On acceptance of requester g: buf_data <= slice g of req$enq_v, buf_full <= 1, last_grant <= g, ptr <= (g+1) mod NUM_REQ.
REQ-019 ptr SHALL NOT change in cycles without an acceptance.
REQ-020 pipe$enq__ENA = buf_full & pipe$enq__RDY; pipe$enq_v = buf_data whenever buf_full.
REQ-021 Drain: when pipe$enq__ENA is high, the message is delivered; buf_full <= 0 unless a new acceptance occurs in the same cycle, in which case buf_full stays 1 with the new data.
REQ-022 Latency: message accepted in cycle n is offered downstream from cycle n+1; with pipe$enq__RDY held high, throughput is one message per cycle.
REQ-023 msg_count increments by 1 on every cycle with pipe$enq__ENA high; wraps 0xFFFF -> 0x0000.
REQ-024 Buffered message SHALL be held unchanged while buf_full & !pipe$enq__RDY (backpressure); no requester is granted during that time.
REQ-025 Starvation bound: a requester holding ENA is accepted within NUM_REQ acceptances.

Reset
REQ-026 While nRST low: buf_full=0, ptr=0, last_grant=0, msg_count=0, pipe$enq__ENA=0, req$enq__RDY=0, regardless of CLK.
REQ-027 Reset asserted mid-operation discards any buffered message without delivering it; msg_count does not count it.
REQ-028 After nRST rises, the first grant follows REQ-017 with ptr=0 on the next rising edge.

Verification
REQ-029 Single requester: ENA[2]=1, data 0x...ABCD, pipe RDY=1 -> RDY[2]=1 in cycle 0, pipe ENA=1 with 0x...ABCD in cycle 1, msg_count=1, last_grant=2.
REQ-030 All four ENA held high, pipe RDY=1 -> grant order 0,1,2,3,0 over five cycles; msg_count=5 after six cycles.
REQ-031 Backpressure: buffer full, pipe RDY=0 for 3 cycles -> req RDY all 0, pipe_v stable, pipe ENA 0; RDY=1 -> delivered once, next grant same cycle.
REQ-032 msg_count preset near wrap by delivering 65535 messages -> next delivery reads 0x0000.
REQ-033 nRST low while buffer full and pipe RDY=0 -> pipe ENA=0 immediately, buffer empty, ptr=0; after release the message is never delivered.
REQ-034 ptr=3, ENA = 0b0101 -> requester 0 granted, then 2, then 0.
